// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO read-side stream stage.
package async_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int PKT_CNT_W      = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/stream_skid_buf2.sv
// Two-entry FIFO-ordered buffer that absorbs the FIFO read latency.
// Head entry always drives valid/head_data; occupancy is exposed for debug.
module stream_skid_buf2
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            occ
);

  occ_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, tail_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case ({push, pop})
      2'b10: begin
        case (state_q)
          EMPTY:   state_d = ONE;
          ONE:     state_d = TWO;
          default: state_d = state_q;
        endcase
      end
      2'b01: begin
        case (state_q)
          TWO:     state_d = ONE;
          ONE:     state_d = EMPTY;
          default: state_d = state_q;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  // Head is the oldest word; a pop in TWO promotes the tail into the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) head_q <= data_in;
        end
        ONE: begin
          if (push && pop) head_q <= data_in;
          else if (push)   tail_q <= data_in;
        end
        TWO: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q <= data_in;
          end
        end
        default: begin
          head_q <= head_q;
        end
      endcase
    end
  end

  assign valid     = (state_q != EMPTY);
  assign head_data = head_q;
  assign occ       = state_q;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-domain consumer: issues FIFO reads, buffers the returned words and
// presents a valid/ready stream framed into PKT_LEN-beat packets.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PKT_LEN    = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [PKT_CNT_W-1:0]  pkt_cnt,
  output logic [1:0]            dbg_occ
);

  // Stream handshake: a beat transfers when m_valid && m_ready at a rising
  // edge; m_valid never drops and m_data/m_last stay put until that happens.

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic                 inflight_q;
  logic [15:0]          beat_q;
  logic [PKT_CNT_W-1:0] pkt_cnt_q;
  logic                 buf_valid;
  logic                 pop;
  logic [1:0]           occ;
  logic [2:0]           level;

  stream_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst_n     (rd_rst_n),
    .push      (inflight_q),
    .data_in   (rd_data),
    .pop       (pop),
    .valid     (buf_valid),
    .head_data (m_data),
    .occ       (occ)
  );

  assign pop   = buf_valid && m_ready;
  // Words held or on their way after this edge; never exceeds the 2 slots.
  // A pop implies occ >= 1, so the subtraction cannot underflow.
  assign level = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  // Gated by reset so no read is requested while the FIFO pointer is held.
  assign rd_en = rd_rst_n && !empty && (level < 3'd2);

  assign m_valid = buf_valid;
  assign m_last  = buf_valid && (beat_q == LAST_BEAT);
  assign pkt_cnt = pkt_cnt_q;
  assign dbg_occ = occ;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      inflight_q <= 1'b0;
      beat_q     <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      inflight_q <= rd_en;
      if (pop) begin
        if (m_last) begin
          beat_q    <= '0;
          pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end else begin
          beat_q <= beat_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Bench for async_fifo_rd_stream: two instances (PKT_LEN 4 and 7) driven by a
// behavioural FIFO, with an expected-word queue checked by a negedge monitor.
module tb_async_fifo_rd_stream;

  localparam int DW   = 32;
  localparam int PL_A = 4;
  localparam int PL_B = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          empty_s   [2];
  logic [DW-1:0] rd_data_s [2];
  logic          rd_en_s   [2];
  logic          m_valid_s [2];
  logic          m_ready_s [2];
  logic [DW-1:0] m_data_s  [2];
  logic          m_last_s  [2];
  logic [15:0]   pkt_cnt_s [2];
  logic [1:0]    dbg_occ_s [2];

  async_fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL_A)) dut_a (
    .rd_clk(clk), .rd_rst_n(rst_n), .empty(empty_s[0]), .rd_data(rd_data_s[0]),
    .rd_en(rd_en_s[0]), .m_valid(m_valid_s[0]), .m_ready(m_ready_s[0]),
    .m_data(m_data_s[0]), .m_last(m_last_s[0]), .pkt_cnt(pkt_cnt_s[0]),
    .dbg_occ(dbg_occ_s[0])
  );

  async_fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL_B)) dut_b (
    .rd_clk(clk), .rd_rst_n(rst_n), .empty(empty_s[1]), .rd_data(rd_data_s[1]),
    .rd_en(rd_en_s[1]), .m_valid(m_valid_s[1]), .m_ready(m_ready_s[1]),
    .m_data(m_data_s[1]), .m_last(m_last_s[1]), .pkt_cnt(pkt_cnt_s[1]),
    .dbg_occ(dbg_occ_s[1])
  );

  // Reference state: unread FIFO contents, words read but not yet emitted,
  // and running counts of reads/accepted beats since the last reset.
  logic [DW-1:0] src_q [2][$];
  logic [DW-1:0] exp_q [2][$];
  int            req_total [2];
  int            pop_total [2];
  int            beat_m    [2];
  logic [15:0]   pkt_m     [2];
  logic          prev_req  [2];
  logic          prev_dut_rd [2];
  int            plen      [2] = '{PL_A, PL_B};

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor + FIFO responder: samples at negedge, answers reads after posedge.
  initial begin : monitor
    logic req [2];
    bit   prev_rst_low;
    int   infl, occ, lvl;
    bit   ev, pop, erd;
    prev_rst_low = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        req[i] = 1'b0;
        if (!rst_n) begin
          if (prev_rst_low) begin
            chk(m_valid_s[i] == 1'b0, $sformatf("rst_m_valid%0d", i), DW'(m_valid_s[i]), 0);
            chk(rd_en_s[i] == 1'b0, $sformatf("rst_rd_en%0d", i), DW'(rd_en_s[i]), 0);
            chk(pkt_cnt_s[i] == 16'h0, $sformatf("rst_pkt_cnt%0d", i), DW'(pkt_cnt_s[i]), 0);
            chk(m_data_s[i] == '0, $sformatf("rst_m_data%0d", i), m_data_s[i], 0);
            chk(m_last_s[i] == 1'b0, $sformatf("rst_m_last%0d", i), DW'(m_last_s[i]), 0);
          end
          exp_q[i].delete();
          req_total[i] = 0; pop_total[i] = 0; beat_m[i] = 0; pkt_m[i] = 16'h0;
          prev_req[i] = 1'b0; prev_dut_rd[i] = 1'b0;
        end else begin
          infl = int'(prev_req[i]);
          occ  = req_total[i] - infl - pop_total[i];
          ev   = (occ > 0);
          pop  = ev && m_ready_s[i];
          chk(m_valid_s[i] == ev, $sformatf("m_valid%0d", i), DW'(m_valid_s[i]), DW'(ev));
          lvl  = occ + infl - int'(pop);
          erd  = !empty_s[i] && (lvl < 2);
          chk(rd_en_s[i] == erd, $sformatf("rd_en%0d", i), DW'(rd_en_s[i]), DW'(erd));
          chk(!(prev_dut_rd[i] && dbg_occ_s[i] == 2'd2 && !(m_valid_s[i] && m_ready_s[i])),
              $sformatf("push_in_two%0d", i), DW'(dbg_occ_s[i]), 2);
          chk(pkt_cnt_s[i] == pkt_m[i], $sformatf("pkt_cnt%0d", i), DW'(pkt_cnt_s[i]), DW'(pkt_m[i]));
          if (ev) begin
            if (exp_q[i].size() == 0) begin
              chk(1'b0, $sformatf("exp_underrun%0d", i), m_data_s[i], 0);
            end else begin
              chk(m_data_s[i] == exp_q[i][0], $sformatf("m_data%0d", i), m_data_s[i], exp_q[i][0]);
              chk(m_last_s[i] == (beat_m[i] == plen[i] - 1), $sformatf("m_last%0d", i),
                  DW'(m_last_s[i]), DW'(beat_m[i] == plen[i] - 1));
            end
          end
          if (pop) begin
            if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
            pop_total[i]++;
            if (beat_m[i] == plen[i] - 1) begin
              beat_m[i] = 0;
              pkt_m[i]  = pkt_m[i] + 16'd1;
            end else begin
              beat_m[i]++;
            end
          end
          req[i]         = rd_en_s[i];
          req_total[i]  += int'(rd_en_s[i]);
          prev_req[i]    = rd_en_s[i];
          prev_dut_rd[i] = rd_en_s[i];
        end
      end
      prev_rst_low = !rst_n;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (src_q[i].size() == 0) begin
            chk(1'b0, $sformatf("fifo_underflow%0d", i), 1, 0);
            rd_data_s[i] = $urandom;
          end else begin
            rd_data_s[i] = src_q[i].pop_front();
            exp_q[i].push_back(rd_data_s[i]);
          end
        end else begin
          rd_data_s[i] = $urandom;
        end
        empty_s[i] = (src_q[i].size() == 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n = 0;
    while ((src_q[i].size() != 0 || exp_q[i].size() != 0 || req_total[i] != pop_total[i])
           && n < budget) begin
      tick();
      n++;
    end
    chk(n < budget, $sformatf("drain_timeout%0d", i), DW'(n), DW'(budget));
  endtask

  initial begin : stim
    int base, base_pop, n, pushed;
    for (int i = 0; i < 2; i++) begin
      empty_s[i] = 1'b1; m_ready_s[i] = 1'b0; rd_data_s[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Streaming 12 words into the PKT_LEN=4 instance with m_ready held high.
    for (int w = 0; w < 12; w++) src_q[0].push_back(DW'(w));
    m_ready_s[0] = 1'b1;
    wait_idle(0, 100);
    chk(pkt_cnt_s[0] == 16'd3, "stream_pkt_cnt", DW'(pkt_cnt_s[0]), 3);

    // Backpressure: two reads fill the buffer, then reads stop.
    m_ready_s[0] = 1'b0;
    base = req_total[0];
    for (int w = 0; w < 8; w++) src_q[0].push_back(DW'(32'h100 + w));
    repeat (10) tick();
    chk(req_total[0] - base == 2, "bp_rd_en_pulses", DW'(req_total[0] - base), 2);
    chk(m_valid_s[0] == 1'b1, "bp_valid_held", DW'(m_valid_s[0]), 1);
    chk(m_data_s[0] == 32'h100, "bp_data_held", m_data_s[0], 32'h100);
    m_ready_s[0] = 1'b1;
    wait_idle(0, 100);
    chk(pkt_cnt_s[0] == 16'd5, "bp_pkt_cnt", DW'(pkt_cnt_s[0]), 5);

    // Single word: FIFO goes empty right after the read, word must still appear.
    base = req_total[0];
    base_pop = pop_total[0];
    src_q[0].push_back(32'hABCD_0001);
    repeat (8) tick();
    chk(req_total[0] - base == 1, "empty_rd_en_count", DW'(req_total[0] - base), 1);
    chk(pop_total[0] - base_pop == 1, "empty_word_out", DW'(pop_total[0] - base_pop), 1);

    // Reset with one word buffered and one in flight; neither may reappear.
    m_ready_s[0] = 1'b0;
    base = req_total[0];
    for (int w = 0; w < 6; w++) src_q[0].push_back(DW'(32'h200 + w));
    n = 0;
    while (req_total[0] - base < 2 && n < 20) begin
      tick();
      n++;
    end
    chk(n < 20, "rst_fill_timeout", DW'(n), 20);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    m_ready_s[0] = 1'b1;
    n = 0;
    while (!m_valid_s[0] && n < 20) begin
      tick();
      n++;
    end
    chk(m_data_s[0] == 32'h202, "rst_first_word", m_data_s[0], 32'h202);
    wait_idle(0, 100);

    // pkt_cnt wrap: preset to 0xFFFF, then complete one packet.
    m_ready_s[0] = 1'b0;
    tick();
    force dut_a.pkt_cnt_q = 16'hFFFF;
    pkt_m[0] = 16'hFFFF;
    tick();
    release dut_a.pkt_cnt_q;
    tick();
    for (int w = 0; w < PL_A; w++) src_q[0].push_back(DW'(32'h300 + w));
    m_ready_s[0] = 1'b1;
    wait_idle(0, 100);
    chk(pkt_cnt_s[0] == 16'h0000, "pkt_wrap", DW'(pkt_cnt_s[0]), 0);
    m_ready_s[0] = 1'b0;

    // Random traffic and random backpressure on the PKT_LEN=7 instance.
    pushed = 0;
    n = 0;
    while ((pushed < 1000 || src_q[1].size() != 0 || exp_q[1].size() != 0
            || req_total[1] != pop_total[1]) && n < 20000) begin
      m_ready_s[1] = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        src_q[1].push_back(DW'($urandom));
        pushed++;
      end
      tick();
      n++;
    end
    chk(n < 20000, "rand_timeout", DW'(n), 20000);
    chk(pop_total[1] == 1000, "rand_beats", DW'(pop_total[1]), 1000);
    chk(pkt_cnt_s[1] == 16'd142, "rand_pkt_cnt", DW'(pkt_cnt_s[1]), 142);
    m_ready_s[1] = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_stream.md
# async_fifo_rd_stream

Read-side consumer stage of the asynchronous FIFO, running entirely in the read clock domain. It pulls words from the FIFO read port (rd_en / rd_data / empty), absorbs the one-cycle read latency in a 2-entry output buffer, and presents a valid/ready stream to downstream logic. It also frames the stream into fixed-length packets (m_last) and counts completed packets.

## Interface
- DATA_WIDTH, 32, FIFO word and stream data width
- PKT_LEN, 16, beats per packet; legal range 1..65535
- rd_clk  input  1  read-domain clock; all state updates on rising edge
- rd_rst_n  input  1  reset; synchronous, active-low
- empty  input  1  FIFO empty flag, rd_clk domain
- rd_data  input  DATA_WIDTH  FIFO read data; valid the cycle after rd_en
- rd_en  output  1  FIFO read request
- m_valid  output  1  stream beat valid
- m_ready  input  1  downstream accept
- m_data  output  DATA_WIDTH  stream data
- m_last  output  1  final beat of packet, qualified by m_valid
- pkt_cnt  output  16  completed packets; wraps at 2^16

## Operation
- Reset (rd_rst_n=0 at a rising edge): rd_en=0, m_valid=0, m_data=0, m_last=0, pkt_cnt=0, beat counter=0, occupancy=EMPTY, in-flight flag=0. Reset mid-operation drops buffered and in-flight words without emitting them. rd_rst_n also resets the FIFO read pointer, so no stale data is returned after reset.
- Occupancy FSM states are EMPTY, ONE and TWO.
  - Push: the in-flight flag is set this cycle, so rd_data is written into the buffer.
  - Pop: m_valid && m_ready.
  - Transitions: push without pop moves up one state. Pop without push moves down one state. Push and pop together hold the state.
- rd_en = !empty && (occ + inflight − pop) < 2.
  - occ is 0/1/2 for EMPTY/ONE/TWO.
  - rd_en is combinational from registered state, empty and m_ready. This is a deliberate path that gives full throughput.
- inflight <= rd_en at every edge.
- The buffer is FIFO-ordered. m_data/m_valid always come from the head entry.
- A push when occupancy is TWO with no pop is impossible by construction. The bench asserts this never happens.
- Beat counter counts 0..PKT_LEN−1.
  - m_last = m_valid && (beat == PKT_LEN−1).
  - On pop, beat increments. If the pop had m_last set, beat wraps to 0 and pkt_cnt increments.
  - When PKT_LEN=1, every beat is last.
- empty rising while a read is in flight is legal. The in-flight word is still captured.

## Timing
- rd_en in cycle t means rd_data is sampled at the end of t+1, and m_valid is high in t+2. The latency from rd_en to first m_valid is 2 cycles.
- From empty falling to m_valid rising takes 2 cycles when the buffer starts empty.
- With continuous m_ready=1 and the FIFO non-empty, throughput is one beat per cycle after fill.
- m_ready=0 stalls. At most 2 words are buffered, and rd_en stays low while occ+inflight=2.
- m_valid never drops without a pop. m_data and m_last are stable while m_valid && !m_ready.
- pkt_cnt updates in the cycle after the last beat is accepted.

## Structure
- async_fifo_pkg holds:
  - occ_state_e enum (EMPTY, ONE, TWO)
  - DATA_WIDTH default constant
  - PKT_CNT_W = 16
- Sub-module stream_skid_buf2 holds the 2-entry buffer: push/data_in, pop, head data, occupancy.
- The top level holds rd_en logic, the in-flight flag, the beat counter and pkt_cnt.

## Test plan
- Reset mid-stream:
  - Stimulus: rd_rst_n=0 with occ=TWO and inflight=1.
  - Required response: next cycle m_valid=0, rd_en=0, pkt_cnt=0. After release, the first word out is the FIFO's next word; buffered words are not replayed.
- Streaming with PKT_LEN=4:
  - Stimulus: FIFO preloaded with 0x0..0xB, m_ready=1.
  - Required response: 12 beats on consecutive cycles starting 2 cycles after the first rd_en, m_last on 0x3, 0x7 and 0xB, final pkt_cnt=3.
- Backpressure:
  - Stimulus: m_ready=0 for 10 cycles with the FIFO non-empty.
  - Required response: exactly 2 rd_en pulses, then rd_en=0, and m_data held at the first word. After release, data is in order with no loss or duplication.
- Empty boundary:
  - Stimulus: a single word written, and empty asserts in the cycle after rd_en.
  - Required response: the word is still emitted and no further rd_en is issued.
- Random m_ready (50%) with 1000 random words, PKT_LEN=7:
  - Required response: output order matches input exactly.
  - pkt_cnt = 142, and m_last appears every 7th beat.
  - The FSM never pushes while in TWO without a pop.
- pkt_cnt wrap:
  - Stimulus: force pkt_cnt to 0xFFFF, then complete one packet.
  - Required response: pkt_cnt = 0x0000.
